// File: rtl/load_pkg.sv
// Shared definitions for the load sequencer: load-type codes, FSM states and a
// helper that maps a load type to its access size.
package load_pkg;

  // Load-type codes as driven on the load_type port.
  typedef enum logic [2:0] {
    LdLw  = 3'b000,
    LdLh  = 3'b001,
    LdLhu = 3'b010,
    LdLb  = 3'b011,
    LdLbu = 3'b100
  } load_type_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  // Unknown codes behave as a word load.
  function automatic logic [2:0] norm_type(input logic [2:0] lt);
    logic [2:0] res;
    case (lt)
      LdLh, LdLhu, LdLb, LdLbu: res = lt;
      default:                  res = LdLw;
    endcase
    return res;
  endfunction

  // Access size in bytes.
  function automatic logic [2:0] load_size(input logic [2:0] lt);
    logic [2:0] res;
    case (lt)
      LdLh, LdLhu: res = 3'd2;
      LdLb, LdLbu: res = 3'd1;
      default:     res = 3'd4;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of the assembled load bytes according to load type.
module load_extend
  import load_pkg::*;
(
  input  logic [2:0]  load_type,
  input  logic [31:0] data,
  output logic [31:0] result
);

  // Select the extension for the requested width.
  always_comb begin
    result = data;
    case (load_type)
      LdLh:    result = {{16{data[15]}}, data[15:0]};
      LdLhu:   result = {16'h0000, data[15:0]};
      LdLb:    result = {{24{data[7]}}, data[7:0]};
      LdLbu:   result = {24'h000000, data[7:0]};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/load_sequencer.sv
// Multi-beat load sequencer: issues bus-aligned reads, assembles the bytes of a
// load in address order and returns the extended 32-bit result.
// Optional macro UNALIGNED_LOAD_EN: perform misaligned LH/LHU/LW by spanning
// bus words instead of rejecting them.
module load_sequencer
  import load_pkg::*;
#(
  parameter int unsigned BUS_W  = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        load_type,
  input  logic [ADDR_W-1:0] addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [BUS_W-1:0]  mem_rd_data,
  input  logic              mem_rd_valid,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              rsp_misalign
);

  localparam int unsigned      Bytes    = BUS_W / 8;
  localparam logic [ADDR_W-1:0] LaneMask = ADDR_W'(Bytes - 1);
  localparam logic [ADDR_W-1:0] BeatStep = ADDR_W'(Bytes);

  state_e            state_q, state_d;
  logic [2:0]        type_q, type_d;
  logic [2:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] beat_addr_q, beat_addr_d;
  logic [2:0]        beats_q, beats_d;
  logic              misalign_q, misalign_d;
  logic [31:0]       asm_q, asm_d;

  logic [2:0]  req_type;
  logic [2:0]  req_size;
  logic [2:0]  req_beats;
  logic        req_reject;
  logic [31:0] ext_data;

  // Decode the incoming request: type, size, beat count and reject decision.
  always_comb begin
    req_type = norm_type(load_type);
    req_size = load_size(req_type);
`ifdef UNALIGNED_LOAD_EN
    req_reject = 1'b0;
    // Number of bus words touched by bytes addr .. addr+size-1.
    req_beats  = 3'((32'(addr & LaneMask) + 32'(req_size) + Bytes - 1) / Bytes);
`else
    req_reject = (((req_type == LdLh) || (req_type == LdLhu)) && addr[0]) ||
                 ((req_type == LdLw) && (addr[1:0] != 2'b00));
    req_beats  = (32'(req_size) >= Bytes) ? 3'(32'(req_size) / Bytes) : 3'd1;
`endif
  end

  // Offset of each bus lane relative to the load address; lanes outside
  // 0..size-1 are not part of the load (wraps negative, so compares large).
  logic [ADDR_W-1:0] lane_off [Bytes];
  for (genvar g = 0; g < Bytes; g++) begin : g_lane
    assign lane_off[g] = beat_addr_q + ADDR_W'(g) - addr_q;
  end

  // FSM next state and datapath next-state.
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    size_d      = size_q;
    addr_d      = addr_q;
    beat_addr_d = beat_addr_q;
    beats_d     = beats_q;
    misalign_d  = misalign_q;
    asm_d       = asm_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          type_d      = req_type;
          size_d      = req_size;
          addr_d      = addr;
          beat_addr_d = addr & ~LaneMask;
          beats_d     = req_beats;
          misalign_d  = req_reject;
          asm_d       = '0;
          state_d     = req_reject ? StResp : StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (mem_rd_valid) begin
          for (int unsigned b = 0; b < Bytes; b++) begin
            if (lane_off[b] < ADDR_W'(size_q)) begin
              asm_d[{lane_off[b][1:0], 3'b000} +: 8] = mem_rd_data[8*b +: 8];
            end
          end
          beats_d = beats_q - 3'd1;
          if (beats_q == 3'd1) begin
            state_d = StResp;
          end else begin
            beat_addr_d = beat_addr_q + BeatStep;
            state_d     = StIssue;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      type_q      <= LdLw;
      size_q      <= 3'd0;
      addr_q      <= '0;
      beat_addr_q <= '0;
      beats_q     <= 3'd0;
      misalign_q  <= 1'b0;
      asm_q       <= '0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      beat_addr_q <= beat_addr_d;
      beats_q     <= beats_d;
      misalign_q  <= misalign_d;
      asm_q       <= asm_d;
    end
  end

  load_extend u_extend (
    .load_type (type_q),
    .data      (asm_q),
    .result    (ext_data)
  );

  // Outputs decoded from state; response fields are zero outside RESP.
  always_comb begin
    req_ready    = (state_q == StIdle);
    mem_rd_en    = (state_q == StIssue);
    mem_addr     = beat_addr_q;
    rsp_valid    = (state_q == StResp);
    rsp_misalign = (state_q == StResp) && misalign_q;
    rsp_data     = ((state_q == StResp) && !misalign_q) ? ext_data : 32'h0;
  end

endmodule

// File: tb/tb_load_sequencer.sv
// Directed bench for load_sequencer: a 32-bit and a 16-bit bus instance share a
// byte-addressed memory model with programmable read latency.
module tb_load_sequencer;

  typedef struct {
    bit          use16;
    logic [2:0]  lt;
    logic [31:0] addr;
    int          lat;
    logic [31:0] exp_data;
    logic        exp_mis;
    int          exp_lat;
    int          exp_beats;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  load_type = 3'b000;
  logic [31:0] addr = 32'h0;
  logic        rv32 = 1'b0, rv16 = 1'b0;

  logic        rdy32, en32, val32, rsp32, mis32;
  logic [31:0] maddr32, data32, rdat32;
  logic        rdy16, en16, val16, rsp16, mis16;
  logic [31:0] maddr16, data16;
  logic [15:0] rdat16;

  int  total = 0;
  int  bad = 0;
  int  lat = 1;
  bit  sel16 = 1'b0;

  logic [7:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  load_sequencer #(.BUS_W(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst(rst), .req_valid(rv32), .req_ready(rdy32), .load_type(load_type),
    .addr(addr), .mem_rd_en(en32), .mem_addr(maddr32), .mem_rd_data(rdat32),
    .mem_rd_valid(val32), .rsp_valid(rsp32), .rsp_data(data32), .rsp_misalign(mis32)
  );

  load_sequencer #(.BUS_W(16), .ADDR_W(32)) dut16 (
    .clk(clk), .rst(rst), .req_valid(rv16), .req_ready(rdy16), .load_type(load_type),
    .addr(addr), .mem_rd_en(en16), .mem_addr(maddr16), .mem_rd_data(rdat16),
    .mem_rd_valid(val16), .rsp_valid(rsp16), .rsp_data(data16), .rsp_misalign(mis16)
  );

  function automatic logic [31:0] rd(input logic [31:0] a, input int n);
    logic [31:0] r = 32'h0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] ba = a + 32'(i);
      if (mem.exists(ba)) r[8*i +: 8] = mem[ba];
    end
    return r;
  endfunction

  task automatic put_word(input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < 4; i++) mem[a + 32'(i)] = d[8*i +: 8];
  endtask

  // Memory responders: data appears 'lat' cycles after the strobe cycle.
  int          cnt32, cnt16;
  bit          pend32 = 1'b0, pend16 = 1'b0;
  logic [31:0] pa32, pa16;
  always @(posedge clk) begin
    val32 <= 1'b0;
    if (en32) begin
      if (lat <= 1) begin
        val32 <= 1'b1; rdat32 <= rd(maddr32, 4);
      end else begin
        pend32 <= 1'b1; cnt32 <= lat - 1; pa32 <= maddr32;
      end
    end else if (pend32) begin
      if (cnt32 == 1) begin
        val32 <= 1'b1; rdat32 <= rd(pa32, 4); pend32 <= 1'b0;
      end
      cnt32 <= cnt32 - 1;
    end
  end
  always @(posedge clk) begin
    val16 <= 1'b0;
    if (en16) begin
      if (lat <= 1) begin
        val16 <= 1'b1; rdat16 <= rd(maddr16, 2)[15:0];
      end else begin
        pend16 <= 1'b1; cnt16 <= lat - 1; pa16 <= maddr16;
      end
    end else if (pend16) begin
      if (cnt16 == 1) begin
        val16 <= 1'b1; rdat16 <= rd(pa16, 2)[15:0]; pend16 <= 1'b0;
      end
      cnt16 <= cnt16 - 1;
    end
  end

  logic        s_rdy, s_en, s_rsp, s_mis;
  logic [31:0] s_addr, s_data;
  assign s_rdy  = sel16 ? rdy16 : rdy32;
  assign s_en   = sel16 ? en16 : en32;
  assign s_rsp  = sel16 ? rsp16 : rsp32;
  assign s_mis  = sel16 ? mis16 : mis32;
  assign s_addr = sel16 ? maddr16 : maddr32;
  assign s_data = sel16 ? data16 : data32;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit u16, input logic [2:0] lt, input logic [31:0] a,
                              input int l, input logic [31:0] d, input logic m, input int el,
                              input int eb, input logic [31:0] ef, input logic [31:0] ell);
    vec_t v;
    v.use16 = u16; v.lt = lt; v.addr = a; v.lat = l; v.exp_data = d; v.exp_mis = m;
    v.exp_lat = el; v.exp_beats = eb; v.exp_first = ef; v.exp_last = ell;
    return v;
  endfunction

  // Issue one request and watch it through to the response.
  task automatic run_vec(input int idx, input vec_t v);
    int k = 1;
    bit got = 0, busy_bad = 0, idle_bad = 0;
    int strobes = 0;
    logic [31:0] first_a = 32'h0, last_a = 32'h0;
    lat = v.lat;
    sel16 = v.use16;
    @(negedge clk);
    load_type = v.lt; addr = v.addr;
    if (v.use16) rv16 = 1'b1; else rv32 = 1'b1;
    @(negedge clk);
    rv16 = 1'b0; rv32 = 1'b0;
    while (!got && k <= 40) begin
      if (s_en) begin
        if (strobes == 0) first_a = s_addr;
        last_a = s_addr;
        strobes++;
      end
      if (s_rsp) got = 1;
      else begin
        if (s_rdy) busy_bad = 1;
        if (s_data != 32'h0 || s_mis) idle_bad = 1;
        @(negedge clk);
        k++;
      end
    end
    check($sformatf("v%0d_rsp_seen", idx), 32'(got), 32'd1);
    check($sformatf("v%0d_data", idx), s_data, v.exp_data);
    check($sformatf("v%0d_misalign", idx), 32'(s_mis), 32'(v.exp_mis));
    check($sformatf("v%0d_latency", idx), k, v.exp_lat);
    check($sformatf("v%0d_beats", idx), strobes, v.exp_beats);
    if (v.exp_beats > 0) begin
      check($sformatf("v%0d_first_addr", idx), first_a, v.exp_first);
      check($sformatf("v%0d_last_addr", idx), last_a, v.exp_last);
    end
    check($sformatf("v%0d_busy_ready", idx), 32'(busy_bad), 32'd0);
    check($sformatf("v%0d_idle_zero", idx), 32'(idle_bad), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d_ready_after", idx), 32'(s_rdy), 32'd1);
    check($sformatf("v%0d_pulse_one", idx), 32'(s_rsp), 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    bit saw_rsp = 0, saw_en = 0;
    put_word(32'h100, 32'h80AA5511);
    put_word(32'h104, 32'h44332211);
    put_word(32'h200, 32'h12345678);
    put_word(32'h300, 32'h80FF0000);
    put_word(32'h400, 32'h0BADF00D);
    put_word(32'h500, 32'hDEADBEEF);

    //           16  type    addr      lat data          mis lat beats first     last
    vecs.push_back(mk(0, 3'b011, 32'h103, 1, 32'hFFFFFF80, 0, 3, 1, 32'h100, 32'h100));
    vecs.push_back(mk(0, 3'b100, 32'h103, 1, 32'h00000080, 0, 3, 1, 32'h100, 32'h100));
    vecs.push_back(mk(0, 3'b011, 32'h101, 1, 32'h00000055, 0, 3, 1, 32'h100, 32'h100));
    vecs.push_back(mk(0, 3'b000, 32'h100, 1, 32'h80AA5511, 0, 3, 1, 32'h100, 32'h100));
    vecs.push_back(mk(0, 3'b001, 32'h102, 1, 32'hFFFF80AA, 0, 3, 1, 32'h100, 32'h100));
    vecs.push_back(mk(0, 3'b010, 32'h102, 1, 32'h000080AA, 0, 3, 1, 32'h100, 32'h100));
    vecs.push_back(mk(0, 3'b001, 32'h100, 1, 32'h00005511, 0, 3, 1, 32'h100, 32'h100));
`ifdef UNALIGNED_LOAD_EN
    vecs.push_back(mk(0, 3'b001, 32'h301, 1, 32'hFFFFFF00, 0, 3, 1, 32'h300, 32'h300));
    vecs.push_back(mk(0, 3'b000, 32'h102, 1, 32'h221180AA, 0, 5, 2, 32'h100, 32'h104));
`else
    vecs.push_back(mk(0, 3'b001, 32'h301, 1, 32'h00000000, 1, 1, 0, 32'h0, 32'h0));
    vecs.push_back(mk(0, 3'b000, 32'h102, 1, 32'h00000000, 1, 1, 0, 32'h0, 32'h0));
`endif
    vecs.push_back(mk(0, 3'b111, 32'h400, 1, 32'h0BADF00D, 0, 3, 1, 32'h400, 32'h400));
    vecs.push_back(mk(0, 3'b010, 32'h402, 3, 32'h00000BAD, 0, 5, 1, 32'h400, 32'h400));
    vecs.push_back(mk(1, 3'b000, 32'h200, 1, 32'h12345678, 0, 5, 2, 32'h200, 32'h202));
    vecs.push_back(mk(1, 3'b000, 32'h200, 2, 32'h12345678, 0, 7, 2, 32'h200, 32'h202));
    vecs.push_back(mk(1, 3'b011, 32'h203, 1, 32'h00000012, 0, 3, 1, 32'h202, 32'h202));
    vecs.push_back(mk(1, 3'b001, 32'h202, 1, 32'h00001234, 0, 3, 1, 32'h202, 32'h202));
    vecs.push_back(mk(1, 3'b100, 32'h200, 1, 32'h00000078, 0, 3, 1, 32'h200, 32'h200));

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready32", 32'(rdy32), 32'd1);
    check("rst_ready16", 32'(rdy16), 32'd1);
    check("rst_outs32", {en32, rsp32, mis32}, 32'd0);
    check("rst_data32", data32, 32'h0);
    check("rst_maddr32", maddr32, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Reset while waiting on a slow read: no response, late data ignored.
    lat = 5;
    sel16 = 1'b0;
    @(negedge clk);
    load_type = 3'b000; addr = 32'h500; rv32 = 1'b1;
    @(negedge clk);
    rv32 = 1'b0;
    check("abort_strobe", 32'(en32), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ready_now", 32'(rdy32), 32'd1);
    check("abort_no_rsp", 32'(rsp32), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp32) saw_rsp = 1;
      if (en32) saw_en = 1;
    end
    check("abort_late_rsp", 32'(saw_rsp), 32'd0);
    check("abort_late_strobe", 32'(saw_en), 32'd0);
    check("abort_idle_ready", 32'(rdy32), 32'd1);
    check("abort_data_zero", data32, 32'h0);
    run_vec(100, mk(0, 3'b100, 32'h101, 1, 32'h00000055, 0, 3, 1, 32'h100, 32'h100));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
